pipe_reg_chain: RTL and testbench

- Parametrised elastic pipeline register: STAGES register stages, each WIDTH bits wide.
- Each stage carries its own valid bit, with a valid/ready handshake on both ends.
- Generalises the plain 32-bit enable register used between processor/plotter pipeline stages. Adds:
  - configurable width and depth;
  - per-stage bubble collapsing under backpressure;
  - synchronous flush;
  - an occupancy count.
- Sits between datapath stages (e.g. decode→execute, command queue→motor controller) to absorb stalls without losing data.

---
 rtl/pipe_reg_chain_if.sv | 23 ++
 rtl/pipe_reg_chain.sv | 99 +++++++++
 tb/tb_pipe_reg_chain.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_reg_chain_if.sv
// Upstream/downstream valid-ready bus for pipe_reg_chain, plus the flush strobe.
interface pipe_reg_chain_if #(
  parameter int unsigned WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  // master drives the chain (producer + consumer side), slave is the chain itself
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_reg_chain.sv
// Elastic valid/ready pipeline register chain with bubble collapse, flush and occupancy count.
// Optional macro PIPE_REG_CHAIN_CLEAR_DATA_EN: zero data on flush and whenever a stage drains.
module pipe_reg_chain #(
  parameter int unsigned  WIDTH  = 32,
  parameter int unsigned  STAGES = 3,
  localparam int unsigned CNT_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  pipe_reg_chain_if.slave   bus,
  output logic [STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0] v_q, v_d;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [CNT_W-1:0]  occ_q, occ_d;

  logic [STAGES-1:0] adv_c;
  logic [STAGES-1:0] move_c;
  logic              in_rdy_c;
  logic              accept_c;

  // A stage may advance if the next one is empty or itself advancing.
  always_comb begin
    adv_c       = '0;
    adv_c[LAST] = bus.out_ready;
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      adv_c[i] = ~v_q[i+1] | adv_c[i+1];
    end
  end

  assign move_c   = v_q & adv_c;
  assign in_rdy_c = (~v_q[0] | adv_c[0]) & ~bus.flush;
  assign accept_c = bus.in_valid & in_rdy_c;

  assign bus.in_ready  = in_rdy_c;
  assign bus.out_valid = v_q[LAST] & ~bus.flush;
  assign bus.out_data  = d_q[LAST];
  assign stage_valid   = v_q;
  assign occupancy     = occ_q;

  // Next state: flush kills everything, otherwise load / drain / hold per stage.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (bus.flush) begin
      v_d = '0;
`ifdef PIPE_REG_CHAIN_CLEAR_DATA_EN
      for (int i = 0; i < int'(STAGES); i++) begin
        d_d[i] = '0;
      end
`endif
    end else begin
      if (accept_c) begin
        v_d[0] = 1'b1;
        d_d[0] = bus.in_data;
      end else if (move_c[0] | ~v_q[0]) begin
        v_d[0] = 1'b0;
`ifdef PIPE_REG_CHAIN_CLEAR_DATA_EN
        d_d[0] = '0;
`endif
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        if (move_c[i-1]) begin
          v_d[i] = 1'b1;
          d_d[i] = d_q[i-1];
        end else if (move_c[i] | ~v_q[i]) begin
          v_d[i] = 1'b0;
`ifdef PIPE_REG_CHAIN_CLEAR_DATA_EN
          d_d[i] = '0;
`endif
        end
      end
    end
    occ_d = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      occ_d = occ_d + CNT_W'(v_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      d_q   <= d_d;
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain (WIDTH=32, STAGES=3): directed scenarios plus
// randomized traffic against a queue-of-entries reference model.
module tb_pipe_reg_chain;

  localparam int W = 32;
  localparam int S = 3;

  typedef struct {
    int           pos;
    logic [W-1:0] data;
  } ent_t;

  logic         clk;
  logic         rst;
  logic [S-1:0] stage_valid;
  logic [1:0]   occupancy;

  int vectors;
  int miscompares;

  ent_t q[$];   // oldest entry first; pos = stage index it occupies

  pipe_reg_chain_if #(.WIDTH(W)) bus ();

  pipe_reg_chain #(.WIDTH(W), .STAGES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .stage_valid(stage_valid),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  // Reference: each entry moves one step forward unless blocked by the entry ahead.
  function automatic logic mdl_in_ready();
    int lim;
    lim = S;
    if (bus.flush) return 1'b0;
    foreach (q[k]) begin
      if (k == 0 && q[k].pos == S - 1 && bus.out_ready) continue;
      lim = (q[k].pos + 1 < lim - 1) ? q[k].pos + 1 : lim - 1;
    end
    return lim >= 1;
  endfunction

  function automatic logic [S-1:0] mdl_stage_valid();
    logic [S-1:0] sv;
    sv = '0;
    foreach (q[k]) sv[q[k].pos] = 1'b1;
    return sv;
  endfunction

  function automatic logic mdl_out_valid();
    return (q.size() > 0) && (q[0].pos == S - 1) && !bus.flush;
  endfunction

  task automatic mdl_update();
    logic acc;
    logic drop;
    int   lim;
    acc  = bus.in_valid && mdl_in_ready();
    drop = 1'b0;
    lim  = S;
    if (rst || bus.flush) begin
      q.delete();
    end else begin
      foreach (q[k]) begin
        if (k == 0 && q[k].pos == S - 1 && bus.out_ready) begin
          drop = 1'b1;
        end else begin
          q[k].pos = (q[k].pos + 1 < lim - 1) ? q[k].pos + 1 : lim - 1;
          lim      = q[k].pos;
        end
      end
      if (drop) void'(q.pop_front());
      if (acc) q.push_back('{pos: 0, data: bus.in_data});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== 32'h0) begin miscompares++; $display("FAIL reset out_data: got %h want 0", bus.out_data); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
    vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("FAIL reset occupancy: got %0d want 0", occupancy); end
    vectors++; if (stage_valid !== 3'b000) begin miscompares++; $display("FAIL reset stage_valid: got %b want 000", stage_valid); end
    tick();
  endtask

  task automatic test_stream();
    logic [W-1:0] exp[$];
    exp = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int c = 0; c < 8; c++) begin
      drive(c < 4, W'((c + 1) * 17), 1'b1, 1'b0);
      @(negedge clk);
      if (c == 3) begin
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11) begin miscompares++; $display("FAIL stream latency: got v=%b d=%h want v=1 d=11", bus.out_valid, bus.out_data); end
      end
      if (c == 3 || c == 4) begin
        vectors++; if (occupancy !== 2'd3) begin miscompares++; $display("FAIL stream occupancy c=%0d: got %0d want 3", c, occupancy); end
      end
      if (bus.out_valid === 1'b1) begin
        vectors++;
        if (exp.size() == 0) begin miscompares++; $display("FAIL stream extra output: got %h want none", bus.out_data); end
        else begin
          if (bus.out_data !== exp[0]) begin miscompares++; $display("FAIL stream order: got %h want %h", bus.out_data, exp[0]); end
          void'(exp.pop_front());
        end
      end
      tick();
    end
    vectors++; if (exp.size() != 0) begin miscompares++; $display("FAIL stream missing outputs: got %0d left want 0", exp.size()); end
  endtask

  task automatic test_full_stall();
    logic [W-1:0] exp[$];
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, W'(32'hA + c), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'hD, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++; if (occupancy !== 2'd3) begin miscompares++; $display("FAIL full occupancy: got %0d want 3", occupancy); end
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL full in_ready: got %b want 0", bus.in_ready); end
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b1 || bus.out_data !== 32'hA) begin miscompares++; $display("FAIL full release: got rdy=%b d=%h want rdy=1 d=a", bus.in_ready, bus.out_data); end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    exp = '{32'hB, 32'hC, 32'hD};
    @(negedge clk);
    vectors++; if (occupancy !== 2'd3) begin miscompares++; $display("FAIL full swap occupancy: got %0d want 3", occupancy); end
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp[c]) begin miscompares++; $display("FAIL full order %0d: got v=%b d=%h want %h", c, bus.out_valid, bus.out_data, exp[c]); end
      tick();
    end
  endtask

  task automatic test_bubble();
    drive(1'b1, 32'h5A5A_0001, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h5A5A_0002, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    vectors++; if (stage_valid !== 3'b101) begin miscompares++; $display("FAIL bubble setup: got %b want 101", stage_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bubble in_ready: got %b want 1", bus.in_ready); end
    tick();
    @(negedge clk);
    vectors++; if (stage_valid !== 3'b110) begin miscompares++; $display("FAIL bubble collapse: got %b want 110", stage_valid); end
    vectors++; if (bus.in_ready !== 1'b1 || occupancy !== 2'd2) begin miscompares++; $display("FAIL bubble after: got rdy=%b occ=%0d want rdy=1 occ=2", bus.in_ready, occupancy); end
    vectors++; if (bus.out_data !== 32'h5A5A_0001) begin miscompares++; $display("FAIL bubble head: got %h want 5a5a0001", bus.out_data); end
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL flush in_ready: got %b want 0", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush out_valid: got %b want 0", bus.out_valid); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    vectors++; if (occupancy !== 2'd0 || stage_valid !== 3'b000) begin miscompares++; $display("FAIL flush state: got occ=%0d sv=%b want 0/000", occupancy, stage_valid); end
    vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL flush after: got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
`ifdef PIPE_REG_CHAIN_CLEAR_DATA_EN
    vectors++; if (bus.out_data !== 32'h0) begin miscompares++; $display("FAIL flush data: got %h want 0", bus.out_data); end
`else
    vectors++; if (bus.out_data !== 32'h5A5A_0001) begin miscompares++; $display("FAIL flush data: got %h want 5a5a0001", bus.out_data); end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, W'(32'hC0DE_0000 + c), 1'b0, 1'b0);
      tick();
    end
    @(negedge clk);
    vectors++; if (occupancy !== 2'd3) begin miscompares++; $display("FAIL rstmid fill: got %0d want 3", occupancy); end
    rst = 1'b1;
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    vectors++; if (occupancy !== 2'd0 || stage_valid !== 3'b000) begin miscompares++; $display("FAIL rstmid state: got occ=%0d sv=%b want 0/000", occupancy, stage_valid); end
    vectors++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin miscompares++; $display("FAIL rstmid out: got v=%b d=%h want 0/0", bus.out_valid, bus.out_data); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid in_ready: got %b want 1", bus.in_ready); end
    tick();
  endtask

  task automatic test_random();
    int thr;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      case (c / 100)
        0:       thr = 80;
        1:       thr = 30;
        2:       thr = 60;
        default: thr = 10;
      endcase
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 99) < thr),
            1'($urandom_range(0, 15) == 0));
      @(negedge clk);
      vectors++; if (bus.in_ready !== mdl_in_ready()) begin miscompares++; $display("FAIL rand in_ready c=%0d: got %b want %b", c, bus.in_ready, mdl_in_ready()); end
      vectors++; if (bus.out_valid !== mdl_out_valid()) begin miscompares++; $display("FAIL rand out_valid c=%0d: got %b want %b", c, bus.out_valid, mdl_out_valid()); end
      if (mdl_out_valid()) begin
        vectors++; if (bus.out_data !== q[0].data) begin miscompares++; $display("FAIL rand out_data c=%0d: got %h want %h", c, bus.out_data, q[0].data); end
      end
      vectors++; if (stage_valid !== mdl_stage_valid()) begin miscompares++; $display("FAIL rand stage_valid c=%0d: got %b want %b", c, stage_valid, mdl_stage_valid()); end
      vectors++; if (occupancy !== 2'(q.size())) begin miscompares++; $display("FAIL rand occupancy c=%0d: got %0d want %0d", c, occupancy, q.size()); end
      mdl_update();
      tick();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    test_reset();
    test_stream();
    test_full_stall();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
